// File: rtl/scr1_dmem_tcm_router_if.sv
// ---------------------------------------------------------------------------
// scr1_dmem_tcm_router_if
//
// One data-memory bus link: request channel (req/cmd/width/addr/wdata),
// request acceptance (req_ack) and response channel (resp/rdata).
//
// Handshake semantics for every link built on this interface:
//   - A request transfers in the cycle where req && req_ack are both high.
//     req_ack may depend combinationally on req/addr.
//   - After a transfer the requester waits for exactly one response:
//     resp 2'b01 = ready (rdata valid for reads), 2'b10 = error,
//     2'b00 = nothing this cycle. Each non-zero resp is a one-cycle pulse.
//
// Modports:
//   master : the side that issues requests (drives req/cmd/width/addr/wdata)
//   slave  : the side that accepts requests (drives req_ack/rdata/resp)
// ---------------------------------------------------------------------------
interface scr1_dmem_tcm_router_if;
  logic        req_ack;
  logic        req;
  logic        cmd;
  logic [1:0]  width;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  resp;

  modport master (
    input  req_ack,
    input  rdata,
    input  resp,
    output req,
    output cmd,
    output width,
    output addr,
    output wdata
  );

  modport slave (
    output req_ack,
    output rdata,
    output resp,
    input  req,
    input  cmd,
    input  width,
    input  addr,
    input  wdata
  );
endinterface

// File: rtl/scr1_dmem_tcm_router.sv
// ---------------------------------------------------------------------------
// scr1_dmem_tcm_router
//
// Routes core data-memory requests either to the tightly-coupled memory
// (TCM) or to the external bus bridge, based on the request address.
// Exactly one transaction may be outstanding; the port that owns it is
// remembered in port_q and its response/read data are steered back to the
// core. The request path is purely combinational, so a TCM that answers in
// the next cycle sustains one access per cycle.
//
// Ports:
//   clk          : clock, all state updates on rising edge
//   rst_n        : asynchronous active-low reset
//   dmem_if      : core side (slave modport)
//   tcm_if       : TCM side (master modport)
//   ext_if       : external bridge side (master modport)
//   dbg_state_o  : current FSM state (0 IDLE, 1 WAIT, 2 FLUSH)
//   dbg_port_o   : port owning the outstanding transaction (0 TCM, 1 EXT)
//
// Optional feature, enabled by defining SCR1_ROUTER_TIMEOUT_EN:
//   a WAIT that sees no response for SCR1_ROUTER_TIMEOUT cycles is reported
//   to the core as an error; the router then sits in FLUSH, refusing new
//   requests, until the stalled port finally answers (that answer is
//   dropped). Without the macro WAIT lasts until the port responds.
// ---------------------------------------------------------------------------
module scr1_dmem_tcm_router #(
  parameter logic [31:0] SCR1_TCM_ADDR_MASK    = 32'hFFFF_0000,
  parameter logic [31:0] SCR1_TCM_ADDR_PATTERN = 32'h0048_0000
`ifdef SCR1_ROUTER_TIMEOUT_EN
  ,
  parameter int unsigned SCR1_ROUTER_TIMEOUT   = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  scr1_dmem_tcm_router_if.slave         dmem_if,
  scr1_dmem_tcm_router_if.master        tcm_if,
  scr1_dmem_tcm_router_if.master        ext_if,
  output logic [1:0]                    dbg_state_o,
  output logic                          dbg_port_o
);

  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  localparam logic PORT_TCM = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        port_q,  port_d;

  logic        sel_tcm;
  logic        sel_port;
  logic        sel_ack;
  logic [1:0]  port_resp;
  logic [31:0] port_rdata;
  logic        resp_done;
  logic        accept_ok;
  logic        handshake;
  logic        timeout_hit;
  logic [1:0]  core_resp;
  logic [31:0] core_rdata;

  // -------------------------------------------------------------------------
  // Address decode and response selection
  // -------------------------------------------------------------------------
  assign sel_tcm  = ((dmem_if.addr & SCR1_TCM_ADDR_MASK) == SCR1_TCM_ADDR_PATTERN);
  assign sel_port = sel_tcm ? PORT_TCM : PORT_EXT;
  assign sel_ack  = sel_tcm ? tcm_if.req_ack : ext_if.req_ack;

  // Only the port owning the outstanding transaction is listened to; a
  // response from the other port (or in IDLE) never reaches the core.
  assign port_resp  = (port_q == PORT_TCM) ? tcm_if.resp  : ext_if.resp;
  assign port_rdata = (port_q == PORT_TCM) ? tcm_if.rdata : ext_if.rdata;

  assign resp_done = (state_q == ST_WAIT) && (port_resp != RESP_IDLE);

  // A new request may go out when nothing is pending, or in the very cycle
  // the pending one completes -- this is what gives back-to-back throughput
  // and lets a request to the other port overlap the last response.
  assign accept_ok = (state_q == ST_IDLE) || resp_done;
  assign handshake = dmem_if.req && accept_ok && sel_ack;

  // -------------------------------------------------------------------------
  // Request fan-out: payload goes to both ports, req only to the chosen one
  // -------------------------------------------------------------------------
  assign tcm_if.req   = dmem_if.req && accept_ok && sel_tcm;
  assign tcm_if.cmd   = dmem_if.cmd;
  assign tcm_if.width = dmem_if.width;
  assign tcm_if.addr  = dmem_if.addr;
  assign tcm_if.wdata = dmem_if.wdata;

  assign ext_if.req   = dmem_if.req && accept_ok && !sel_tcm;
  assign ext_if.cmd   = dmem_if.cmd;
  assign ext_if.width = dmem_if.width;
  assign ext_if.addr  = dmem_if.addr;
  assign ext_if.wdata = dmem_if.wdata;

  assign dmem_if.req_ack = accept_ok && sel_ack;
  assign dmem_if.resp    = core_resp;
  assign dmem_if.rdata   = core_rdata;

  // -------------------------------------------------------------------------
  // Response timeout (optional)
  // -------------------------------------------------------------------------
`ifdef SCR1_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(SCR1_ROUTER_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCR1_ROUTER_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed silent WAIT cycles, so in the k-th WAIT cycle
  // after the handshake it holds k-1 and the error fires in cycle
  // SCR1_ROUTER_TIMEOUT after acceptance.
  assign timeout_hit = (state_q == ST_WAIT) && (port_resp == RESP_IDLE) &&
                       (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_WAIT) && (port_resp == RESP_IDLE) && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      port_q  <= PORT_TCM;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and core-side response
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    port_d     = handshake ? sel_port : port_q;
    core_resp  = RESP_IDLE;
    core_rdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        core_resp  = port_resp;
        core_rdata = port_rdata;
        if (resp_done) begin
          state_d = handshake ? ST_WAIT : ST_IDLE;
        end else if (timeout_hit) begin
          core_resp = RESP_ERR;
          state_d   = ST_FLUSH;
        end
      end

`ifdef SCR1_ROUTER_TIMEOUT_EN
      // The late response of the stalled port is swallowed here so that it
      // cannot be mistaken for the answer to a later request.
      ST_FLUSH: begin
        if (port_resp != RESP_IDLE) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dbg_state_o = state_q;
  assign dbg_port_o  = port_q;

endmodule

// File: tb/tb_scr1_dmem_tcm_router.sv
// ---------------------------------------------------------------------------
// tb_scr1_dmem_tcm_router
//
// Directed scenarios for the router followed by randomized single
// transactions. The bench plays the core and both target ports. Expected
// responses are queued when a transaction is issued and popped when the
// owning port answers; port ownership is derived from the TCM address
// window 0x0048_0000..0x0048_FFFF.
// ---------------------------------------------------------------------------
module tb_scr1_dmem_tcm_router;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic       dbg_port;

  scr1_dmem_tcm_router_if dmem_bus ();
  scr1_dmem_tcm_router_if tcm_bus ();
  scr1_dmem_tcm_router_if ext_bus ();

  scr1_dmem_tcm_router dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmem_if     (dmem_bus),
    .tcm_if      (tcm_bus),
    .ext_if      (ext_bus),
    .dbg_state_o (dbg_state),
    .dbg_port_o  (dbg_port)
  );

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic cmd, input logic [1:0] width,
                           input logic [31:0] addr, input logic [31:0] wdata);
    dmem_bus.req   = 1'b1;
    dmem_bus.cmd   = cmd;
    dmem_bus.width = width;
    dmem_bus.addr  = addr;
    dmem_bus.wdata = wdata;
  endtask

  task automatic set_resp(input bit to_tcm, input logic [1:0] r, input logic [31:0] d);
    if (to_tcm) begin
      tcm_bus.resp  = r;
      tcm_bus.rdata = d;
    end else begin
      ext_bus.resp  = r;
      ext_bus.rdata = d;
    end
  endtask

  task automatic set_ack(input bit to_tcm, input logic a);
    if (to_tcm) tcm_bus.req_ack = a;
    else        ext_bus.req_ack = a;
  endtask

  function automatic logic get_req(input bit from_tcm);
    return from_tcm ? tcm_bus.req : ext_bus.req;
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [31:0] a;
  bit          is_tcm;
  logic        cmd;
  logic [1:0]  wd;
  logic [31:0] wdat;
  logic [1:0]  rk;
  logic [31:0] rd;
  int          lat;
  int          ack_dly;
  logic [33:0] e;

  initial begin
    rst_n            = 1'b0;
    dmem_bus.req     = 1'b0;
    dmem_bus.cmd     = 1'b0;
    dmem_bus.width   = 2'b10;
    dmem_bus.addr    = 32'h0048_0000;
    dmem_bus.wdata   = 32'h0;
    tcm_bus.req_ack  = 1'b1;
    tcm_bus.resp     = 2'b00;
    tcm_bus.rdata    = 32'h0;
    ext_bus.req_ack  = 1'b1;
    ext_bus.resp     = 2'b00;
    ext_bus.rdata    = 32'h0;

    // ---- reset state ----
    #3;
    check("rst_resp",    dmem_bus.resp,    32'h0);
    check("rst_rdata",   dmem_bus.rdata,   32'h0);
    check("rst_tcm_req", tcm_bus.req,      32'h0);
    check("rst_ext_req", ext_bus.req,      32'h0);
    check("rst_req_ack", dmem_bus.req_ack, 32'h1);
    check("rst_state",   dbg_state,        32'h0);
    check("rst_port",    dbg_port,         32'h0);
    #9 rst_n = 1'b1;

    // ---- TCM read, data one cycle later ----
    tick();
    drive_req(1'b0, 2'b10, 32'h0048_0010, 32'h0);
    settle();
    check("tcm_rd_tcm_req", tcm_bus.req,      32'h1);
    check("tcm_rd_ext_req", ext_bus.req,      32'h0);
    check("tcm_rd_ack",     dmem_bus.req_ack, 32'h1);
    tick();
    dmem_bus.req = 1'b0;
    set_resp(1, 2'b01, 32'hDEAD_BEEF);
    settle();
    check("tcm_rd_resp",  dmem_bus.resp,  32'h1);
    check("tcm_rd_rdata", dmem_bus.rdata, 32'hDEAD_BEEF);
    tick();
    set_resp(1, 2'b00, 32'h0);
    settle();
    check("tcm_rd_idle_resp",  dmem_bus.resp,  32'h0);
    check("tcm_rd_idle_rdata", dmem_bus.rdata, 32'h0);

    // ---- EXT word write, response after 3 cycles ----
    tick();
    drive_req(1'b1, 2'b10, 32'h2000_0000, 32'h1234_5678);
    settle();
    check("ext_wr_ext_req", ext_bus.req,      32'h1);
    check("ext_wr_tcm_req", tcm_bus.req,      32'h0);
    check("ext_wr_ack",     dmem_bus.req_ack, 32'h1);
    check("ext_wr_wdata",   ext_bus.wdata,    32'h1234_5678);
    check("ext_wr_cmd",     ext_bus.cmd,      32'h1);
    for (int k = 1; k <= 2; k++) begin
      tick();
      settle();
      check("ext_wr_wait_ack",  dmem_bus.req_ack, 32'h0);
      check("ext_wr_wait_req",  ext_bus.req,      32'h0);
      check("ext_wr_wait_resp", dmem_bus.resp,    32'h0);
    end
    tick();
    dmem_bus.req = 1'b0;
    set_resp(0, 2'b01, 32'h0);
    settle();
    check("ext_wr_resp", dmem_bus.resp, 32'h1);
    tick();
    set_resp(0, 2'b00, 32'h0);
    settle();
    check("ext_wr_idle", dmem_bus.resp, 32'h0);

    // ---- four back-to-back TCM reads ----
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (i < 4) drive_req(1'b0, 2'b10, 32'h0048_0000 + 32'(4 * i), 32'h0);
      else       dmem_bus.req = 1'b0;
      if (i > 0) set_resp(1, 2'b01, 32'hA000_0000 + 32'(i - 1));
      else       set_resp(1, 2'b00, 32'h0);
      settle();
      if (i < 4) check("b2b_ack", dmem_bus.req_ack, 32'h1);
      if (i > 0) begin
        check("b2b_resp",  dmem_bus.resp,  32'h1);
        check("b2b_rdata", dmem_bus.rdata, 32'hA000_0000 + 32'(i - 1));
      end
    end
    tick();
    set_resp(1, 2'b00, 32'h0);
    settle();
    check("b2b_idle", dmem_bus.resp, 32'h0);

    // ---- TCM pending, EXT issued in TCM response cycle, EXT error ----
    tick();
    drive_req(1'b0, 2'b10, 32'h0048_0020, 32'h0);
    settle();
    check("sw_tcm_ack", dmem_bus.req_ack, 32'h1);
    tick();
    drive_req(1'b0, 2'b01, 32'h2000_0004, 32'h0);
    set_resp(1, 2'b01, 32'h1111_1111);
    settle();
    check("sw_ext_req",   ext_bus.req,      32'h1);
    check("sw_tcm_req",   tcm_bus.req,      32'h0);
    check("sw_ext_ack",   dmem_bus.req_ack, 32'h1);
    check("sw_tcm_resp",  dmem_bus.resp,    32'h1);
    check("sw_tcm_rdata", dmem_bus.rdata,   32'h1111_1111);
    tick();
    dmem_bus.req = 1'b0;
    set_resp(1, 2'b00, 32'h0);
    set_resp(0, 2'b10, 32'h0);
    settle();
    check("sw_ext_err", dmem_bus.resp, 32'h2);
    tick();
    set_resp(0, 2'b00, 32'h0);
    settle();
    check("sw_err_one_cycle", dmem_bus.resp, 32'h0);

    // ---- reset during EXT WAIT, stale response ignored ----
    tick();
    drive_req(1'b0, 2'b10, 32'h2000_0008, 32'h0);
    settle();
    check("rw_ack", dmem_bus.req_ack, 32'h1);
    tick();
    dmem_bus.req = 1'b0;
    settle();
    check("rw_in_wait", dbg_state, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rw_state_async", dbg_state,     32'h0);
    check("rw_resp_async",  dmem_bus.resp, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    set_resp(0, 2'b01, 32'h5555_5555);
    settle();
    check("rw_stale_resp",  dmem_bus.resp,  32'h0);
    check("rw_stale_rdata", dmem_bus.rdata, 32'h0);
    tick();
    set_resp(0, 2'b00, 32'h0);
    drive_req(1'b0, 2'b10, 32'h0048_0030, 32'h0);
    settle();
    check("rw_tcm_ack", dmem_bus.req_ack, 32'h1);
    check("rw_tcm_req", tcm_bus.req,      32'h1);
    tick();
    dmem_bus.req = 1'b0;
    set_resp(1, 2'b01, 32'h7777_0000);
    settle();
    check("rw_tcm_resp",  dmem_bus.resp,  32'h1);
    check("rw_tcm_rdata", dmem_bus.rdata, 32'h7777_0000);
    tick();
    set_resp(1, 2'b00, 32'h0);

`ifdef SCR1_ROUTER_TIMEOUT_EN
    // ---- EXT silent: error after 64 cycles, FLUSH until late response ----
    drive_req(1'b0, 2'b10, 32'h2000_0010, 32'h0);
    settle();
    check("to_ack", dmem_bus.req_ack, 32'h1);
    for (int k = 1; k < 64; k++) begin
      tick();
      dmem_bus.req = 1'b0;
      settle();
      check("to_wait_resp", dmem_bus.resp, 32'h0);
    end
    tick();
    settle();
    check("to_err", dmem_bus.resp, 32'h2);
    for (int k = 0; k < 2; k++) begin
      tick();
      drive_req(1'b0, 2'b10, 32'h0048_0040, 32'h0);
      settle();
      check("to_flush_ack",     dmem_bus.req_ack, 32'h0);
      check("to_flush_tcm_req", tcm_bus.req,      32'h0);
      check("to_flush_ext_req", ext_bus.req,      32'h0);
      check("to_flush_resp",    dmem_bus.resp,    32'h0);
    end
    tick();
    set_resp(0, 2'b01, 32'h9999_9999);
    settle();
    check("to_late_resp", dmem_bus.resp,    32'h0);
    check("to_late_ack",  dmem_bus.req_ack, 32'h0);
    tick();
    set_resp(0, 2'b00, 32'h0);
    settle();
    check("to_idle_ack", dmem_bus.req_ack, 32'h1);
    tick();
    dmem_bus.req = 1'b0;
    set_resp(1, 2'b01, 32'h4040_4040);
    settle();
    check("to_next_rdata", dmem_bus.rdata, 32'h4040_4040);
    tick();
    set_resp(1, 2'b00, 32'h0);
`endif

    // ---- randomized single transactions ----
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) a = {16'h0048, 16'($urandom)};
      else                           a = $urandom;
      is_tcm  = (a >= 32'h0048_0000) && (a <= 32'h0048_FFFF);
      cmd     = 1'($urandom_range(0, 1));
      wd      = 2'($urandom_range(0, 2));
      wdat    = $urandom;
      lat     = $urandom_range(1, 4);
      ack_dly = $urandom_range(0, 2);
      rk      = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
      rd      = $urandom;
      exp_q.push_back({rk, rd});

      set_ack(!is_tcm, 1'($urandom_range(0, 1)));
      set_ack(is_tcm, 1'b0);
      drive_req(cmd, wd, a, wdat);
      for (int c = 0; c <= ack_dly; c++) begin
        if (c == ack_dly) set_ack(is_tcm, 1'b1);
        settle();
        check("rnd_tgt_req",   get_req(is_tcm),  32'h1);
        check("rnd_other_req", get_req(!is_tcm), 32'h0);
        check("rnd_ack",       dmem_bus.req_ack, (c == ack_dly) ? 32'h1 : 32'h0);
        check("rnd_tcm_addr",  tcm_bus.addr,     a);
        check("rnd_ext_addr",  ext_bus.addr,     a);
        check("rnd_width",     tcm_bus.width,    32'(wd));
        check("rnd_wdata",     ext_bus.wdata,    wdat);
        check("rnd_cmd",       ext_bus.cmd,      32'(cmd));
        tick();
      end
      dmem_bus.req = 1'b0;
      for (int w = 1; w < lat; w++) begin
        set_resp(!is_tcm, 2'b01, $urandom);
        settle();
        check("rnd_wait_resp", dmem_bus.resp, 32'h0);
        tick();
      end
      set_resp(!is_tcm, 2'b00, 32'h0);
      set_resp(is_tcm, rk, rd);
      e = exp_q.pop_front();
      settle();
      check("rnd_resp", dmem_bus.resp, 32'(e[33:32]));
      if (e[33:32] == 2'b01) check("rnd_rdata", dmem_bus.rdata, e[31:0]);
      tick();
      set_resp(is_tcm, 2'b00, 32'h0);
      settle();
      check("rnd_idle_resp", dmem_bus.resp, 32'h0);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scr1_dmem_tcm_router.md
# scr1_dmem_tcm_router

Address-decoding router between the core data-memory interface and two target ports: the tightly-coupled memory (TCM) and the external bus bridge. Forwards each core request to the port selected by address, tracks the single outstanding transaction, and steers that port's response and read data back to the core. Adds no latency on the request path; one TCM access completes per cycle when requests are back-to-back.

## Interface
- SCR1_TCM_ADDR_MASK, 32'hFFFF0000, mask applied to dmem_addr for TCM decode
- SCR1_TCM_ADDR_PATTERN, 32'h00480000, TCM selected when (dmem_addr & MASK) == PATTERN
- SCR1_ROUTER_TIMEOUT, 64, cycles in WAIT without response before error (used only with timeout feature)

- clk  in  1  clock; one clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dmem_req_ack  out  1  request accepted this cycle
- dmem_req  in  1  core request valid
- dmem_cmd  in  1  0 read, 1 write
- dmem_width  in  2  00 byte, 01 half, 10 word
- dmem_addr  in  32  byte address
- dmem_wdata  in  32  write data
- dmem_rdata  out  32  read data, valid when dmem_resp == 01
- dmem_resp  out  2  00 idle, 01 ready, 10 error
- tcm_req_ack, tcm_req, tcm_cmd, tcm_width, tcm_addr, tcm_wdata, tcm_rdata, tcm_resp: TCM port, same widths/meaning, directions mirrored
- ext_req_ack, ext_req, ext_cmd, ext_width, ext_addr, ext_wdata, ext_rdata, ext_resp: external port, same

## Operation
- sel = TCM if address matches, else EXT. cmd/width/addr/wdata driven to both ports unconditionally; only the selected port's req is asserted.
- FSM states: IDLE, WAIT, FLUSH (FLUSH only with timeout feature). Register port_q records the port of the outstanding transaction.
- accept_ok = (IDLE) or (WAIT and port_q resp != 00). Selected port req = dmem_req & accept_ok. dmem_req_ack = accept_ok & selected port req_ack.
- Handshake fires when dmem_req & dmem_req_ack: state -> WAIT, port_q <= sel.
- WAIT: dmem_resp/dmem_rdata muxed from port_q. Port resp 01 or 10 completes the transaction: next state WAIT if a new handshake fires the same cycle (port_q updated), else IDLE.
- IDLE and FLUSH: dmem_resp = 00, dmem_rdata = 0.
- Error 10 from a port is passed through unchanged for one cycle.
- Only one transaction outstanding; no request is issued to either port while WAIT has no response.
- Response from a non-selected or idle port is ignored.

## Timing
- Reset values: state IDLE, port_q TCM, timeout counter 0; dmem_resp 00, dmem_rdata 0, tcm_req/ext_req 0, dmem_req_ack 1 if selected port acks (combinational).
- Request path combinational, zero cycles. TCM read: req accepted cycle N, dmem_resp 01 with data cycle N+1.
- Back-to-back TCM accesses: one accepted per cycle, responses every cycle.
- Switch TCM->EXT with TCM response pending: EXT request issued in the same cycle TCM responds.
- Async reset mid-transaction: FSM returns to IDLE immediately; the pending port's later response is ignored.

## Configuration
- SCR1_ROUTER_TIMEOUT_EN defined: counter increments each WAIT cycle without response, clears on handshake. At count == SCR1_ROUTER_TIMEOUT-1, dmem_resp = 10 for one cycle, state -> FLUSH. FLUSH: dmem_req_ack = 0, port reqs = 0, until port_q resp != 00 (discarded), then IDLE.
- Not defined: no counter, no FLUSH; WAIT persists until the port responds.

## Test plan
- Read 0x00480010, TCM returns 0xDEADBEEF one cycle later -> tcm_req=1, ext_req=0, dmem_resp=01, dmem_rdata=0xDEADBEEF at N+1.
- Write 0x20000000 word, ext_resp 01 after 3 cycles -> ext_req=1, dmem_req_ack=0 during wait, dmem_resp=01 at cycle N+3.
- Four back-to-back TCM reads 0x00480000..0x0048000C -> four acks in four consecutive cycles, four 01 responses N+1..N+4.
- TCM read pending, then EXT read -> EXT req issued in TCM response cycle; ext_resp 10 -> dmem_resp=10 for one cycle.
- rst_n low during EXT WAIT, then stale ext_resp 01 -> dmem_resp stays 00, next TCM read normal.
- With SCR1_ROUTER_TIMEOUT_EN, timeout 64, EXT silent -> dmem_resp=10 at cycle N+64; dmem_req_ack=0 until ext_resp 01, then IDLE.
